mem_read_arbiter: RTL and testbench

- Shares the single AXI read channel pair (read address + read data) to main memory between NUM_REQ read masters: instruction-cache refill, stream-buffer prefetch and data-cache refill.
- Exactly one burst is outstanding at a time. Winners are chosen round-robin and latched, and read-data beats are routed back to the owner.
- Sits between the cache/prefetch masters and the memory model, in place of their direct AXI hookups.

---
 rtl/mem_read_arbiter_pkg.sv | 39 +++
 rtl/mem_read_arbiter_if.sv | 46 ++++
 rtl/mem_read_arbiter_rr_picker.sv | 33 +++
 rtl/mem_read_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_read_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_read_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory read arbiter.
//   arb_state_t     - arbiter FSM states (IDLE, ADDR, DATA)
//   REQ_*           - requester slot assignment
//   DEF_*           - default field widths
// Also provides default `ADDR_WIDTH / `DATA_WIDTH if the build does not.
// Optional feature macro: MEM_ARB_PERF_EN (with SIMULATION, provides the
// stats_event hook used to log grants).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam int unsigned REQ_ICACHE    = 0;
  localparam int unsigned REQ_SBUF      = 1;
  localparam int unsigned REQ_DCACHE    = 2;

  localparam int unsigned DEF_LEN_WIDTH = 4;
  localparam int unsigned DEF_ID_WIDTH  = 4;
  localparam int unsigned PERF_WIDTH    = 32;

`ifdef MEM_ARB_PERF_EN
`ifdef SIMULATION
  function automatic void stats_event(input string name);
  endfunction
`endif
`endif

endpackage

// File: rtl/mem_read_arbiter_if.sv
// mem_read_arbiter_if: requester-side and memory-side AXI read signals of
// the arbiter.
//   req_*  : per-requester read address / read data handshake (NUM_REQ wide,
//            req_rdata shared and qualified by req_rvalid)
//   mem_*  : single read address / read data channel to main memory
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus memory)

interface mem_read_arbiter_if #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned LEN_WIDTH = 4,
    parameter int unsigned ID_WIDTH  = 4
);
    logic [NUM_REQ-1:0]                   req_arvalid;
    logic [NUM_REQ-1:0][`ADDR_WIDTH-1:0]  req_araddr;
    logic [NUM_REQ-1:0][LEN_WIDTH-1:0]    req_arlen;
    logic [NUM_REQ-1:0]                   req_arready;
    logic [NUM_REQ-1:0]                   req_rvalid;
    logic [`DATA_WIDTH-1:0]               req_rdata;
    logic [NUM_REQ-1:0]                   req_rready;

    logic                                 mem_arvalid;
    logic [`ADDR_WIDTH-1:0]               mem_araddr;
    logic [LEN_WIDTH-1:0]                 mem_arlen;
    logic [ID_WIDTH-1:0]                  mem_arid;
    logic                                 mem_arready;
    logic                                 mem_rvalid;
    logic [`DATA_WIDTH-1:0]               mem_rdata;
    logic                                 mem_rready;

    modport slave (
        input  req_arvalid, req_araddr, req_arlen, req_rready,
        input  mem_arready, mem_rvalid, mem_rdata,
        output req_arready, req_rvalid, req_rdata,
        output mem_arvalid, mem_araddr, mem_arlen, mem_arid, mem_rready
    );

    modport master (
        output req_arvalid, req_araddr, req_arlen, req_rready,
        output mem_arready, mem_rvalid, mem_rdata,
        input  req_arready, req_rvalid, req_rdata,
        input  mem_arvalid, mem_araddr, mem_arlen, mem_arid, mem_rready
    );

endinterface

// File: rtl/mem_read_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req     in  NUM_REQ          request vector
//   rr_ptr  in  clog2(NUM_REQ)   highest-priority index this round
//   grant   out clog2(NUM_REQ)   first set request at or after rr_ptr (wraps)
//   any_req out 1                at least one request is set

module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       any_req
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int unsigned idx;
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                grant   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one AXI read channel to main memory between
// NUM_REQ read masters (0 i-cache refill, 1 stream buffer, 2 d-cache).
// One burst outstanding at a time; winner picked round-robin and latched,
// read beats routed back to the owner only.
//   clk              in   clock
//   rst              in   synchronous reset, active-high
//   perf_wait_cycles out  per-requester saturating wait counters
//                         (only with MEM_ARB_PERF_EN)
//   bus              slave modport of mem_read_arbiter_if
// Optional feature macro: MEM_ARB_PERF_EN.

module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int unsigned ID_WIDTH  = DEF_ID_WIDTH
) (
    input  logic clk,
    input  logic rst,
`ifdef MEM_ARB_PERF_EN
    output logic [NUM_REQ-1:0][PERF_WIDTH-1:0] perf_wait_cycles,
`endif
    mem_read_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t             state, state_nxt;
    logic [IDX_W-1:0]       rr_ptr, owner, pick_idx;
    logic                   any_req;
    logic [`ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]   len_q, beat_cnt;
    logic                   r_hs, last_beat;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req     (bus.req_arvalid),
        .rr_ptr  (rr_ptr),
        .grant   (pick_idx),
        .any_req (any_req)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req)         state_nxt = ADDR;
            ADDR:    if (bus.mem_arready) state_nxt = DATA;
            DATA:    if (last_beat)       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Output logic; req_rdata is a plain pass-through, qualified by req_rvalid
    always_comb begin
        bus.req_arready = '0;
        bus.req_rvalid  = '0;
        bus.req_rdata   = bus.mem_rdata;
        bus.mem_arvalid = 1'b0;
        bus.mem_araddr  = '0;
        bus.mem_arlen   = '0;
        bus.mem_arid    = '0;
        bus.mem_rready  = 1'b0;
        r_hs            = 1'b0;
        last_beat       = 1'b0;
        unique case (state)
            ADDR: begin
                bus.mem_arvalid        = 1'b1;
                bus.mem_araddr         = addr_q;
                bus.mem_arlen          = len_q;
                bus.mem_arid           = ID_WIDTH'(owner);
                bus.req_arready[owner] = bus.mem_arready;
            end
            DATA: begin
                bus.req_rvalid[owner] = bus.mem_rvalid;
                bus.mem_rready        = bus.req_rready[owner];
                r_hs                  = bus.mem_rvalid && bus.req_rready[owner];
                last_beat             = r_hs && (beat_cnt == len_q - LEN_WIDTH'(1));
            end
            default: ;
        endcase
    end

    // Latched request and burst bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            owner    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: if (any_req) begin
                    owner  <= pick_idx;
                    addr_q <= bus.req_araddr[pick_idx];
                    // A zero-length request still moves one beat
                    len_q  <= (bus.req_arlen[pick_idx] == '0) ? LEN_WIDTH'(1)
                                                              : bus.req_arlen[pick_idx];
                end
                ADDR: if (bus.mem_arready) beat_cnt <= '0;
                DATA: if (r_hs) begin
                    beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                    // Just-served owner drops to lowest priority
                    if (last_beat)
                        rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_wait_cycles <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (bus.req_arvalid[i] && !bus.req_arready[i] && (perf_wait_cycles[i] != '1))
                    perf_wait_cycles[i] <= perf_wait_cycles[i] + PERF_WIDTH'(1);
            end
        end
    end
`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (!rst && (state == ADDR) && bus.mem_arready) stats_event("MemArb_grant");
    end
`endif
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: directed plus randomized checks of mem_read_arbiter
// with three requesters. Expected grants come from a round-robin rule over
// the pending set; each burst is checked at transaction level (address
// phase contents, beat routing, beat count, quiet cycle afterwards).

module tb_mem_read_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned LW      = 4;
    localparam int unsigned IW      = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_read_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_WIDTH(LW), .ID_WIDTH(IW)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [NUM_REQ-1:0][31:0] perf;
`endif

    mem_read_arbiter #(.NUM_REQ(NUM_REQ), .LEN_WIDTH(LW), .ID_WIDTH(IW)) dut (
        .clk              (clk),
        .rst              (rst),
`ifdef MEM_ARB_PERF_EN
        .perf_wait_cycles (perf),
`endif
        .bus              (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_quiet(input string tag);
        chk({tag, "_arvalid"}, bus.mem_arvalid, 0);
        chk({tag, "_araddr"},  bus.mem_araddr,  0);
        chk({tag, "_arlen"},   bus.mem_arlen,   0);
        chk({tag, "_arid"},    bus.mem_arid,    0);
        chk({tag, "_arready"}, bus.req_arready, 0);
        chk({tag, "_rvalid"},  bus.req_rvalid,  0);
        chk({tag, "_rready"},  bus.mem_rready,  0);
        chk({tag, "_rdata"},   bus.req_rdata,   bus.mem_rdata);
    endtask

    // Round-robin rule: first pending requester at or after ptr, wrapping.
    function automatic int model_pick(input logic [NUM_REQ-1:0] p, input int ptr);
        for (int k = 0; k < NUM_REQ; k++)
            if (p[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return -1;
    endfunction

    // Entered at the IDLE-cycle negedge with requests already driven.
    // mode 0: clean data, 1: owner rready low stall_len cycles at beat stall_at,
    // 2: random rvalid/rready. Returns at the negedge of the idle cycle after
    // the burst.
    task automatic do_txn(input int own, input logic [31:0] addr, input int elen,
                          input int ar_delay, input int mode,
                          input int stall_at, input int stall_len);
        int beats, stalled, guard;
        logic rv;
        logic [NUM_REQ-1:0] rr;
        #1;
        chk("idle_arvalid", bus.mem_arvalid, 0);
        chk("idle_arready", bus.req_arready, 0);
        @(posedge clk);
        for (int c = 0; c <= ar_delay; c++) begin
            @(negedge clk);
            bus.mem_arready = (c == ar_delay);
            #1;
            chk("ar_valid",    bus.mem_arvalid, 1);
            chk("ar_addr",     bus.mem_araddr,  addr);
            chk("ar_len",      bus.mem_arlen,   elen);
            chk("ar_id",       bus.mem_arid,    own);
            chk("req_arready", bus.req_arready, (c == ar_delay) ? (1 << own) : 0);
            chk("ar_no_rdata", {bus.req_rvalid, bus.mem_rready}, 0);
            @(posedge clk);
        end
        beats = 0; stalled = 0; guard = 0;
        while (beats < elen && guard < 400) begin
            @(negedge clk);
            bus.mem_arready      = 1'b0;
            bus.req_arvalid[own] = 1'b0;
            rv = 1'b1;
            rr = '1;
            if (mode == 2) begin
                rv = ($urandom_range(0, 3) != 0);
                rr = NUM_REQ'($urandom);
            end else if (mode == 1 && beats == stall_at && stalled < stall_len) begin
                rr[own] = 1'b0;
                stalled++;
            end
            bus.mem_rvalid = rv;
            bus.req_rready = rr;
            bus.mem_rdata  = $urandom;
            #1;
            chk("rvalid_route", bus.req_rvalid, rv ? (1 << own) : 0);
            chk("rready_route", bus.mem_rready, rr[own]);
            chk("rdata_pass",   bus.req_rdata,  bus.mem_rdata);
            chk("data_no_ar",   {bus.mem_arvalid, bus.req_arready}, 0);
            if (rv && rr[own]) beats++;
            guard++;
            @(posedge clk);
        end
        chk("beats_done", beats, elen);
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.req_rready = '1;
        bus.mem_rdata  = $urandom;
        #1;
        chk("post_rvalid",  bus.req_rvalid,  0);
        chk("post_rready",  bus.mem_rready,  0);
        chk("post_arvalid", bus.mem_arvalid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NUM_REQ-1:0] pend;
        logic [31:0]        addrs [NUM_REQ];
        logic [LW-1:0]      lens  [NUM_REQ];
        int                 ptr_m, w, k;

        rst = 1'b1;
        bus.req_arvalid = '0;
        bus.req_araddr  = '0;
        bus.req_arlen   = '0;
        bus.req_rready  = '0;
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        repeat (3) @(negedge clk);
        bus.mem_rdata   = 32'hA5A5_5A5A;
        bus.mem_rvalid  = 1'b1;
        bus.req_rready  = '1;
        bus.mem_arready = 1'b1;
        #1;
        chk_all_quiet("reset");
`ifdef MEM_ARB_PERF_EN
        chk("reset_perf", perf, 0);
`endif

        // Contention at reset exit: 0 then 1, then 0 again (1 not twice)
        rst = 1'b0;
        bus.mem_arready = 1'b0;
        bus.req_arvalid = 3'b011;
        bus.req_araddr[REQ_ICACHE] = 32'h0000_2000; bus.req_arlen[REQ_ICACHE] = 4'd4;
        bus.req_araddr[REQ_SBUF]   = 32'h0000_3000; bus.req_arlen[REQ_SBUF]   = 4'd2;
        do_txn(REQ_ICACHE, 32'h0000_2000, 4, 0, 0, 0, 0);
        do_txn(REQ_SBUF,   32'h0000_3000, 2, 0, 0, 0, 0);
`ifdef MEM_ARB_PERF_EN
        chk("perf_wait1", perf[REQ_SBUF],   7);
        chk("perf_wait0", perf[REQ_ICACHE], 1);
`endif
        bus.req_arvalid = 3'b011;
        bus.req_araddr[REQ_ICACHE] = 32'h0000_2040;
        do_txn(REQ_ICACHE, 32'h0000_2040, 4, 0, 0, 0, 0);

        // Single requester, line address 0x100, 4 beats
        bus.req_arvalid = 3'b001;
        bus.req_araddr[REQ_ICACHE] = 32'h0000_0100; bus.req_arlen[REQ_ICACHE] = 4'd4;
        do_txn(REQ_ICACHE, 32'h0000_0100, 4, 0, 0, 0, 0);

        // Address backpressure: mem_arready low for 5 cycles
        bus.req_arvalid = 3'b010;
        bus.req_araddr[REQ_SBUF] = 32'h00AB_CD00; bus.req_arlen[REQ_SBUF] = 4'd3;
        do_txn(REQ_SBUF, 32'h00AB_CD00, 3, 5, 0, 0, 0);

        // Data backpressure: owner rready low 3 cycles at beat 2 of 4
        bus.req_arvalid = 3'b010;
        bus.req_araddr[REQ_SBUF] = 32'h0000_5540; bus.req_arlen[REQ_SBUF] = 4'd4;
        do_txn(REQ_SBUF, 32'h0000_5540, 4, 0, 1, 2, 3);

        // len==0 moves exactly one beat
        bus.req_arvalid = 3'b001;
        bus.req_araddr[REQ_ICACHE] = 32'h0000_7700; bus.req_arlen[REQ_ICACHE] = 4'd0;
        do_txn(REQ_ICACHE, 32'h0000_7700, 1, 0, 0, 0, 0);

        // Reset during the second beat of a 4-beat burst owned by requester 1
        bus.req_arvalid = 3'b010;
        bus.req_araddr[REQ_SBUF] = 32'h0000_9900; bus.req_arlen[REQ_SBUF] = 4'd4;
        @(posedge clk);
        @(negedge clk); bus.mem_arready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_arready = 1'b0; bus.req_arvalid = '0;
        bus.mem_rvalid  = 1'b1; bus.req_rready  = '1;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_all_quiet("midreset");
        // Pointer must be back at 0: requester 0 wins over 1
        rst = 1'b0;
        bus.req_arvalid = 3'b011;
        bus.req_araddr[REQ_ICACHE] = 32'h0000_1230; bus.req_arlen[REQ_ICACHE] = 4'd2;
        bus.req_araddr[REQ_SBUF]   = 32'h0000_4560; bus.req_arlen[REQ_SBUF]   = 4'd3;
        do_txn(REQ_ICACHE, 32'h0000_1230, 2, 0, 0, 0, 0);

        // Randomized traffic against the round-robin rule
        ptr_m = 1;
        pend  = 3'b010;
        for (int i = 0; i < NUM_REQ; i++) begin addrs[i] = '0; lens[i] = '0; end
        addrs[REQ_SBUF] = 32'h0000_4560;
        lens[REQ_SBUF]  = 4'd3;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    addrs[i] = $urandom;
                    lens[i]  = LW'($urandom_range(0, 15));
                end else if (pend[i] && $urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            if (pend == '0) begin
                k = $urandom_range(0, NUM_REQ - 1);
                pend[k]  = 1'b1;
                addrs[k] = $urandom;
                lens[k]  = LW'($urandom_range(0, 15));
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_araddr[i] = addrs[i];
                bus.req_arlen[i]  = lens[i];
            end
            bus.req_arvalid = pend;
            w = model_pick(pend, ptr_m);
            do_txn(w, addrs[w], (lens[w] == 0) ? 1 : int'(lens[w]),
                   $urandom_range(0, 3), 2, 0, 0);
            pend[w] = 1'b0;
            ptr_m   = (w + 1) % NUM_REQ;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
